// File: rtl/imm_pkg.sv
// Shared widths, chunk-kind encodings and FSM state type for the immediate encoder.
package imm_pkg;

  localparam int unsigned IMM_W  = 8;
  localparam int unsigned DATA_W = 16;

  localparam logic [1:0] IMM_KIND_SEXT  = 2'b00;
  localparam logic [1:0] IMM_KIND_UPPER = 2'b01;
  localparam logic [1:0] IMM_KIND_LOWER = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_EMIT_ONE = 2'b01,
    ST_EMIT_HI  = 2'b10,
    ST_EMIT_LO  = 2'b11
  } imm_state_t;

endpackage

// File: rtl/imm_encoder_if.sv
// Value-in / chunk-out stream bundle of the immediate encoder.
// master: the encoder itself; slave: the injector/formatter side.
interface imm_encoder_if;
  import imm_pkg::*;

  logic              i_valValid;
  logic [DATA_W-1:0] i_value;
  logic              o_valReady;
  logic              o_immValid;
  logic [IMM_W-1:0]  o_imm;
  logic [1:0]        o_immKind;
  logic              o_immLast;
  logic              i_immReady;
  logic              o_busy;

  modport master (
    input  i_valValid, i_value, i_immReady,
    output o_valReady, o_immValid, o_imm, o_immKind, o_immLast, o_busy
  );

  modport slave (
    output i_valValid, i_value, i_immReady,
    input  o_valReady, o_immValid, o_imm, o_immKind, o_immLast, o_busy
  );
endinterface

// File: rtl/imm_fit_check.sv
// Decides whether a 16-bit value survives an 8-bit sign-extension round trip.
module imm_fit_check
  import imm_pkg::*;
#(
  parameter bit SPLIT_ALWAYS = 1'b0
) (
  input  logic [DATA_W-1:0] value,
  output logic              fits
);

  // Upper byte must be a pure copy of the byte's sign bit.
  always_comb begin
    fits = (value[DATA_W-1:IMM_W] == {IMM_W{value[IMM_W-1]}}) && !SPLIT_ALWAYS;
  end

endmodule

// File: rtl/imm_encoder.sv
// Splits a 16-bit constant into one SEXT chunk or an UPPER/LOWER chunk pair.
module imm_encoder
  import imm_pkg::*;
#(
  parameter bit SPLIT_ALWAYS = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  imm_encoder_if.master stream
);

  imm_state_t        state;
  imm_state_t        state_next;
  logic [DATA_W-1:0] hold;
  logic              fits;
  logic              accept;

  imm_fit_check #(
    .SPLIT_ALWAYS(SPLIT_ALWAYS)
  ) u_fit_check (
    .value(stream.i_value),
    .fits (fits)
  );

  assign accept = (state == ST_IDLE) && stream.i_valValid;

  // State and hold register; hold only loads on an accepted value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      hold  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        hold <= stream.i_value;
      end
    end
  end

  // Next-state: accept in IDLE, advance on consumer ready in EMIT states.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (stream.i_valValid) begin
          state_next = fits ? ST_EMIT_ONE : ST_EMIT_HI;
        end
      end
      ST_EMIT_ONE: if (stream.i_immReady) state_next = ST_IDLE;
      ST_EMIT_HI:  if (stream.i_immReady) state_next = ST_EMIT_LO;
      ST_EMIT_LO:  if (stream.i_immReady) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state and hold only.
  always_comb begin
    stream.o_valReady = 1'b0;
    stream.o_immValid = 1'b0;
    stream.o_imm      = '0;
    stream.o_immKind  = IMM_KIND_SEXT;
    stream.o_immLast  = 1'b0;
    stream.o_busy     = 1'b1;
    unique case (state)
      ST_IDLE: begin
        stream.o_valReady = 1'b1;
        stream.o_busy     = 1'b0;
      end
      ST_EMIT_ONE: begin
        stream.o_immValid = 1'b1;
        stream.o_imm      = hold[IMM_W-1:0];
        stream.o_immKind  = IMM_KIND_SEXT;
        stream.o_immLast  = 1'b1;
      end
      ST_EMIT_HI: begin
        stream.o_immValid = 1'b1;
        stream.o_imm      = hold[DATA_W-1:IMM_W];
        stream.o_immKind  = IMM_KIND_UPPER;
        stream.o_immLast  = 1'b0;
      end
      ST_EMIT_LO: begin
        stream.o_immValid = 1'b1;
        stream.o_imm      = hold[IMM_W-1:0];
        stream.o_immKind  = IMM_KIND_LOWER;
        stream.o_immLast  = 1'b1;
      end
      default: begin
        stream.o_valReady = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: default instance plus a SPLIT_ALWAYS=1 instance.
module tb_imm_encoder;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  imm_encoder_if bus ();
  imm_encoder_if bus2 ();

  imm_encoder #(.SPLIT_ALWAYS(1'b0)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .stream(bus.master)
  );

  imm_encoder #(.SPLIT_ALWAYS(1'b1)) dut2 (
    .i_clk (clk),
    .i_rst (rst),
    .stream(bus2.master)
  );

  // Observation word: {valid, imm[7:0], kind[1:0], last, valReady, busy}
  logic [13:0] obs;
  logic [13:0] obs2;
  assign obs  = {bus.o_immValid, bus.o_imm, bus.o_immKind, bus.o_immLast, bus.o_valReady, bus.o_busy};
  assign obs2 = {bus2.o_immValid, bus2.o_imm, bus2.o_immKind, bus2.o_immLast, bus2.o_valReady, bus2.o_busy};

  localparam logic [13:0] IDLE_OBS = {1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (obs !== IDLE_OBS) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs, IDLE_OBS); end
    checks++; if (obs2 !== IDLE_OBS) begin failures++; $display("FAIL reset_state_split got=%h exp=%h", obs2, IDLE_OBS); end
  endtask

  task automatic test_fit_positive();
    bus.i_value = 16'h007F; bus.i_valValid = 1'b1; bus.i_immReady = 1'b1;
    tick();
    bus.i_valValid = 1'b0;
    checks++; if (obs !== {1'b1, 8'h7F, 2'b00, 1'b1, 1'b0, 1'b1}) begin failures++; $display("FAIL fit_007f_chunk got=%h exp=%h", obs, {1'b1, 8'h7F, 2'b00, 1'b1, 1'b0, 1'b1}); end
    tick();
    checks++; if (obs !== IDLE_OBS) begin failures++; $display("FAIL fit_007f_ready_back got=%h exp=%h", obs, IDLE_OBS); end
  endtask

  task automatic test_fit_negative();
    logic [15:0] sext;
    bus.i_value = 16'hFF80; bus.i_valValid = 1'b1; bus.i_immReady = 1'b1;
    tick();
    bus.i_valValid = 1'b0;
    checks++; if (obs !== {1'b1, 8'h80, 2'b00, 1'b1, 1'b0, 1'b1}) begin failures++; $display("FAIL fit_ff80_chunk got=%h exp=%h", obs, {1'b1, 8'h80, 2'b00, 1'b1, 1'b0, 1'b1}); end
    sext = {{8{bus.o_imm[7]}}, bus.o_imm};
    checks++; if (sext !== 16'hFF80) begin failures++; $display("FAIL fit_ff80_sext got=%h exp=%h", sext, 16'hFF80); end
    tick();
    checks++; if (obs !== IDLE_OBS) begin failures++; $display("FAIL fit_ff80_idle got=%h exp=%h", obs, IDLE_OBS); end
  endtask

  task automatic test_split();
    bus.i_value = 16'h1234; bus.i_valValid = 1'b1; bus.i_immReady = 1'b1;
    tick();
    bus.i_valValid = 1'b0;
    checks++; if (obs !== {1'b1, 8'h12, 2'b01, 1'b0, 1'b0, 1'b1}) begin failures++; $display("FAIL split_1234_hi got=%h exp=%h", obs, {1'b1, 8'h12, 2'b01, 1'b0, 1'b0, 1'b1}); end
    tick();
    checks++; if (obs !== {1'b1, 8'h34, 2'b10, 1'b1, 1'b0, 1'b1}) begin failures++; $display("FAIL split_1234_lo got=%h exp=%h", obs, {1'b1, 8'h34, 2'b10, 1'b1, 1'b0, 1'b1}); end
    tick();
    checks++; if (obs !== IDLE_OBS) begin failures++; $display("FAIL split_1234_idle got=%h exp=%h", obs, IDLE_OBS); end
  endtask

  task automatic test_backpressure();
    bus.i_value = 16'h0080; bus.i_valValid = 1'b1; bus.i_immReady = 1'b0;
    tick();
    // Offers during the stall must be ignored.
    bus.i_value = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      checks++; if (obs !== {1'b1, 8'h00, 2'b01, 1'b0, 1'b0, 1'b1}) begin failures++; $display("FAIL stall_hi_%0d got=%h exp=%h", i, obs, {1'b1, 8'h00, 2'b01, 1'b0, 1'b0, 1'b1}); end
      if (i < 3) begin
        bus.i_value = 16'h5A5A + 16'(i);
        tick();
      end
    end
    bus.i_valValid = 1'b0; bus.i_immReady = 1'b1;
    tick();
    checks++; if (obs !== {1'b1, 8'h80, 2'b10, 1'b1, 1'b0, 1'b1}) begin failures++; $display("FAIL stall_lo got=%h exp=%h", obs, {1'b1, 8'h80, 2'b10, 1'b1, 1'b0, 1'b1}); end
    tick();
    checks++; if (obs !== IDLE_OBS) begin failures++; $display("FAIL stall_idle got=%h exp=%h", obs, IDLE_OBS); end
  endtask

  task automatic test_reset_mid_emission();
    bus.i_value = 16'hABCD; bus.i_valValid = 1'b1; bus.i_immReady = 1'b0;
    tick();
    bus.i_valValid = 1'b0;
    checks++; if (obs !== {1'b1, 8'hAB, 2'b01, 1'b0, 1'b0, 1'b1}) begin failures++; $display("FAIL abort_hi got=%h exp=%h", obs, {1'b1, 8'hAB, 2'b01, 1'b0, 1'b0, 1'b1}); end
    rst = 1'b1; bus.i_immReady = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (obs !== IDLE_OBS) begin failures++; $display("FAIL abort_reset got=%h exp=%h", obs, IDLE_OBS); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (obs !== IDLE_OBS) begin failures++; $display("FAIL abort_no_lo_%0d got=%h exp=%h", i, obs, IDLE_OBS); end
    end
  endtask

  task automatic test_back_to_back();
    bus.i_value = 16'h0001; bus.i_valValid = 1'b1; bus.i_immReady = 1'b1;
    tick();
    bus.i_value = 16'h8000;
    checks++; if (obs !== {1'b1, 8'h01, 2'b00, 1'b1, 1'b0, 1'b1}) begin failures++; $display("FAIL b2b_first got=%h exp=%h", obs, {1'b1, 8'h01, 2'b00, 1'b1, 1'b0, 1'b1}); end
    tick();
    checks++; if (obs !== IDLE_OBS) begin failures++; $display("FAIL b2b_no_bypass got=%h exp=%h", obs, IDLE_OBS); end
    tick();
    bus.i_valValid = 1'b0;
    checks++; if (obs !== {1'b1, 8'h80, 2'b01, 1'b0, 1'b0, 1'b1}) begin failures++; $display("FAIL b2b_hi got=%h exp=%h", obs, {1'b1, 8'h80, 2'b01, 1'b0, 1'b0, 1'b1}); end
    tick();
    checks++; if (obs !== {1'b1, 8'h00, 2'b10, 1'b1, 1'b0, 1'b1}) begin failures++; $display("FAIL b2b_lo got=%h exp=%h", obs, {1'b1, 8'h00, 2'b10, 1'b1, 1'b0, 1'b1}); end
    tick();
    checks++; if (obs !== IDLE_OBS) begin failures++; $display("FAIL b2b_idle got=%h exp=%h", obs, IDLE_OBS); end
  endtask

  task automatic test_split_always();
    bus2.i_value = 16'h0005; bus2.i_valValid = 1'b1; bus2.i_immReady = 1'b1;
    tick();
    bus2.i_valValid = 1'b0;
    checks++; if (obs2 !== {1'b1, 8'h00, 2'b01, 1'b0, 1'b0, 1'b1}) begin failures++; $display("FAIL split_always_hi got=%h exp=%h", obs2, {1'b1, 8'h00, 2'b01, 1'b0, 1'b0, 1'b1}); end
    tick();
    checks++; if (obs2 !== {1'b1, 8'h05, 2'b10, 1'b1, 1'b0, 1'b1}) begin failures++; $display("FAIL split_always_lo got=%h exp=%h", obs2, {1'b1, 8'h05, 2'b10, 1'b1, 1'b0, 1'b1}); end
    tick();
    checks++; if (obs2 !== IDLE_OBS) begin failures++; $display("FAIL split_always_idle got=%h exp=%h", obs2, IDLE_OBS); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.i_valValid = 1'b0;  bus.i_value = '0;  bus.i_immReady = 1'b0;
    bus2.i_valValid = 1'b0; bus2.i_value = '0; bus2.i_immReady = 1'b1;

    test_reset();
    test_fit_positive();
    test_fit_negative();
    test_split();
    test_backpressure();
    test_reset_mid_emission();
    test_back_to_back();
    test_split_always();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Splits a 16-bit constant into one or two 8-bit instruction immediate fields, the inverse of the core's immediate generator, which sign-extends an 8-bit field to 16 bits. It sits between the debug/boot instruction injector and the instruction formatter. For each value it emits either a single sign-extendable byte, or an upper-byte/lower-byte pair, over a valid/ready stream.

## Interface
- SPLIT_ALWAYS, 0, when 1 every value is emitted as an UPPER/LOWER pair, even if it fits in 8 bits.
- i_clk  input  1  rising-edge clock.
- i_rst  input  1  synchronous, active-high reset.
- i_valValid  input  1  i_value is offered.
- i_value  input  16  constant to encode.
- o_valReady  output  1  encoder can accept a value this cycle.
- o_immValid  output  1  o_imm/o_immKind/o_immLast hold a chunk.
- o_imm  output  8  immediate field for the instruction.
- o_immKind  output  2  chunk kind: 00 SEXT, 01 UPPER, 10 LOWER (11 never driven).
- o_immLast  output  1  final chunk of the current value.
- i_immReady  input  1  consumer accepts the chunk this cycle.
- o_busy  output  1  a value is being emitted (state != IDLE).

## Operation
- Fit test on the accepted value: fits = (i_value[15:8] == {8{i_value[7]}}) && !SPLIT_ALWAYS.
- States: IDLE, EMIT_ONE, EMIT_HI, EMIT_LO.
- IDLE: o_valReady=1. On i_valValid, capture i_value into an internal 16-bit hold register.
  - If fits, go to EMIT_ONE.
  - Otherwise go to EMIT_HI.
- EMIT_ONE: o_imm=hold[7:0], kind SEXT, last=1. Sign-extending o_imm must reproduce hold exactly. Go to IDLE on i_immReady.
- EMIT_HI: o_imm=hold[15:8], kind UPPER, last=0. Go to EMIT_LO on i_immReady.
- EMIT_LO: o_imm=hold[7:0], kind LOWER, last=1. Go to IDLE on i_immReady.
- o_immValid=1 in every EMIT_* state; o_valReady=1 only in IDLE. Input and output handshakes never complete in the same cycle.
- Outputs are registered or decoded only from state and hold. There is no combinational path from i_value or i_valValid to any output.
- Hold register and chunk outputs stay stable while o_immValid=1 and i_immReady=0. i_value changes during that time are ignored.
- i_immReady while o_immValid=0 has no effect. i_valValid while o_valReady=0 has no effect.

## Timing
- Reset (i_rst=1 at a clock edge):
  - State goes to IDLE and hold to 0.
  - Outputs: o_valReady=1, o_immValid=0, o_imm=0, o_immKind=00, o_immLast=0, o_busy=0.
- Reset mid-emission aborts the value. No further chunks of it appear, and no partial pair is completed.
- Latency: value accepted at edge N, first chunk valid from cycle N+1.
- Best-case throughput, with i_immReady held high:
  - A fitting value takes 2 cycles (accept, emit).
  - A split value takes 3 cycles (accept, HI, LO).
- After the last chunk is accepted at edge M, o_valReady=1 in cycle M+1. There is no accept bypass.
- Backpressure: any number of i_immReady=0 cycles stalls in place, with no chunk loss or duplication.

## Structure
- Shared package imm_pkg:
  - Kind encodings IMM_KIND_SEXT=2'b00, IMM_KIND_UPPER=2'b01, IMM_KIND_LOWER=2'b10.
  - 2-bit state encoding for IDLE/EMIT_ONE/EMIT_HI/EMIT_LO.
  - Width constants IMM_W=8, DATA_W=16.
- One sub-module: imm_fit_check. It is combinational; it takes the 16-bit value and SPLIT_ALWAYS and produces fits.
- The FSM and hold register live in imm_encoder.

## Test plan
- Reset, then i_value=16'h007F with valid and i_immReady=1:
  - One chunk, 8'h7F, kind SEXT, last=1.
  - o_valReady back to 1 two cycles after accept.
- i_value=16'hFF80:
  - One chunk, 8'h80, kind SEXT, last=1.
  - Sign-extending 8'h80 gives 16'hFF80.
- i_value=16'h1234:
  - Chunks 8'h12 UPPER last=0, then 8'h34 LOWER last=1, on consecutive cycles.
- i_value=16'h0080 (does not fit) with i_immReady low for 3 cycles, then high:
  - 8'h00 UPPER held stable for 4 cycles.
  - Then 8'h80 LOWER.
  - i_value changes during the stall have no effect.
- i_rst asserted while 8'hAB UPPER of 16'hABCD is pending:
  - Next cycle o_immValid=0, o_valReady=1, o_imm=0.
  - 8'hCD is never emitted.
- SPLIT_ALWAYS=1, i_value=16'h0005:
  - 8'h00 UPPER, then 8'h05 LOWER last=1.
  - The SEXT kind is never driven.
